// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Optional illegal-opcode trap is selected with MCTRL_ILLEGAL_TRAP_EN.
package mctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADR  = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        ADDI_EX  = 4'd8,
        ANDI_EX  = 4'd9,
        IMM_WB   = 4'd10,
        BEQ      = 4'd11,
        BNE      = 4'd12,
        JUMP     = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REG    = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    // Moore decode: the control word is a function of the state alone.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            DECODE:   c.alu_src_b = SRCB_IMM_SH;
            MEM_ADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            RTYPE_EX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            RTYPE_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ANDI_EX: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_AND;
            end
            IMM_WB:   c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a     = SRCA_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_src        = PCSRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            BNE: begin
                c.alu_src_a        = SRCA_REG;
                c.alu_op           = ALUOP_SUB;
                c.pc_src           = PCSRC_ALUOUT;
                c.pc_write_cond_ne = 1'b1;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            TRAP:     c.illegal = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath.
// illegal_op exists only when MCTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               pc_write_cond_ne;
    logic [1:0]         pc_src;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_retired;
    logic [CNT_W-1:0]   instr_count;
    logic               timeout_err;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic               illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_write_cond_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_retired, instr_count,
               timeout_err, illegal_op
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_write_cond_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_retired, instr_count,
               timeout_err, illegal_op
    );
`else
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_write_cond_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_retired, instr_count,
               timeout_err
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_write_cond_ne, pc_src, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, instr_retired, instr_count,
               timeout_err
    );
`endif
endinterface

// File: rtl/mctrl_mem_timer.sv
// Memory wait counter: counts stalled cycles and flags expiry on the
// TMO_CYCLES-th consecutive not-ready cycle (a ready in that cycle wins).
module mctrl_mem_timer #(
    parameter int TMO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic mem_ready,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(TMO_CYCLES + 1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic         stall;

    assign stall  = waiting & ~mem_ready;
    assign expire = stall & (cnt_reg == W'(TMO_CYCLES - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if (clear || expire) begin
            cnt_next = '0;
        end else if (stall) begin
            cnt_next = cnt_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake timeout and retire counter.
// Define MCTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_control
    import mctrl_pkg::*;
#(
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 32,
    parameter int TMO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_if.master bus
);
    state_t           state_reg;
    state_t           state_next;
    ctrl_t            ctrl_reg;
    logic [CNT_W-1:0] count_reg;
    logic             timeout_reg;
    logic             retire;
    logic             waiting;
    logic             in_fetch;
    logic             expire;

    assign in_fetch = (state_reg == FETCH);
    assign waiting  = in_fetch || (state_reg == MEM_RD) || (state_reg == MEM_WR);

    mctrl_mem_timer #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .waiting  (waiting),
        .mem_ready(bus.mem_ready),
        .clear    (state_next != state_reg),
        .expire   (expire)
    );

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_next = DECODE;
                end else if (expire) begin
                    state_next = FETCH;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_next = RTYPE_EX;
                    OP_LW, OP_SW: state_next = MEM_ADR;
                    OP_BEQ:       state_next = BEQ;
                    OP_BNE:       state_next = BNE;
                    OP_ADDI:      state_next = ADDI_EX;
                    OP_ANDI:      state_next = ANDI_EX;
                    OP_J:         state_next = JUMP;
                    default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                        state_next = TRAP;
`else
                        state_next = FETCH;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            MEM_ADR:  state_next = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (bus.mem_ready) begin
                    state_next = MEM_WB;
                end else if (expire) begin
                    state_next = FETCH;
                end
            end
            MEM_WR: begin
                // The store retires in its ready cycle; a timeout abandons it silently.
                if (bus.mem_ready) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end else if (expire) begin
                    state_next = FETCH;
                end
            end
            RTYPE_EX: state_next = RTYPE_WB;
            ADDI_EX,
            ANDI_EX:  state_next = IMM_WB;
            MEM_WB, RTYPE_WB, IMM_WB, BEQ, BNE, JUMP: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    // Control word is registered from the next state so it always matches state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            ctrl_reg    <= decode_state(FETCH);
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode_state(state_next);
            if (retire) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            if (expire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // Fetch side effects only land in the cycle the instruction word arrives.
    assign bus.pc_write         = ctrl_reg.pc_write & (~in_fetch | bus.mem_ready);
    assign bus.ir_write         = ctrl_reg.ir_write & bus.mem_ready;
    assign bus.pc_write_cond    = ctrl_reg.pc_write_cond;
    assign bus.pc_write_cond_ne = ctrl_reg.pc_write_cond_ne;
    assign bus.pc_src           = ctrl_reg.pc_src;
    assign bus.i_or_d           = ctrl_reg.i_or_d;
    assign bus.mem_read         = ctrl_reg.mem_read;
    assign bus.mem_write        = ctrl_reg.mem_write;
    assign bus.mem_to_reg       = ctrl_reg.mem_to_reg;
    assign bus.reg_dst          = ctrl_reg.reg_dst;
    assign bus.reg_write        = ctrl_reg.reg_write;
    assign bus.alu_src_a        = ctrl_reg.alu_src_a;
    assign bus.alu_src_b        = ctrl_reg.alu_src_b;
    assign bus.alu_op           = ALUOP_W'(ctrl_reg.alu_op);
    assign bus.instr_retired    = retire;
    assign bus.instr_count      = count_reg;
    assign bus.timeout_err      = timeout_reg;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op       = ctrl_reg.illegal;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (CNT_W=4, TMO_CYCLES=16).
// Follows the MCTRL_ILLEGAL_TRAP_EN build for the unknown-opcode case.
module tb_multicycle_control;
    import mctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(2), .CNT_W(4)) bus ();

    multicycle_control #(
        .ALUOP_W   (2),
        .CNT_W     (4),
        .TMO_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    // {pcw pcc pcne | pc_src | i_or_d mrd mwr irw | m2r rdst rwr srca | srcb | aluop}
    localparam logic [16:0] W_FETCH_WAIT = 17'b000_00_0100_0000_01_00;
    localparam logic [16:0] W_FETCH_RDY  = 17'b100_00_0101_0000_01_00;
    localparam logic [16:0] W_DECODE     = 17'b000_00_0000_0000_11_00;
    localparam logic [16:0] W_MEM_ADR    = 17'b000_00_0000_0001_10_00;
    localparam logic [16:0] W_MEM_RD     = 17'b000_00_1100_0000_00_00;
    localparam logic [16:0] W_MEM_WB     = 17'b000_00_0000_1010_00_00;
    localparam logic [16:0] W_MEM_WR     = 17'b000_00_1010_0000_00_00;
    localparam logic [16:0] W_RTYPE_EX   = 17'b000_00_0000_0001_00_10;
    localparam logic [16:0] W_RTYPE_WB   = 17'b000_00_0000_0110_00_00;
    localparam logic [16:0] W_ADDI_EX    = 17'b000_00_0000_0001_10_00;
    localparam logic [16:0] W_ANDI_EX    = 17'b000_00_0000_0001_10_11;
    localparam logic [16:0] W_IMM_WB     = 17'b000_00_0000_0010_00_00;
    localparam logic [16:0] W_BEQ        = 17'b010_01_0000_0001_00_01;
    localparam logic [16:0] W_BNE        = 17'b001_01_0000_0001_00_01;
    localparam logic [16:0] W_JUMP       = 17'b100_10_0000_0000_00_00;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    localparam logic [16:0] W_TRAP       = 17'b000_00_0000_0000_00_00;
`endif

    typedef struct {
        logic [22:0] v;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors  = 0;
    int          checks  = 0;
    logic [3:0]  exp_cnt = 4'd0;
    logic        exp_tmo = 1'b0;
    logic [22:0] act;

    // Monitor: every negedge with a pending expectation compares the full output word.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            act = {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.pc_src,
                   bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.instr_retired, bus.instr_count,
                   bus.timeout_err};
            checks++;
            if (act !== mon_e.v) begin
                errors++;
                $display("FAIL %s: got %b required %b", mon_e.tag, act, mon_e.v);
            end else begin
                $display("ok   %s: %b", mon_e.tag, act);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // One clock of stimulus; called at posedge+1, expectation checked at the next negedge.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [16:0] w,
                       input logic ret, input string tag);
        exp_t e;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        e.v   = {w, ret, exp_cnt, exp_tmo};
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (ret) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic instr_short(input logic [5:0] op, input logic [16:0] w_ex, input string tag);
        cyc(op, 1'b1, W_FETCH_RDY, 1'b0, {tag, "_fetch"});
        cyc(op, 1'b0, W_DECODE,    1'b0, {tag, "_decode"});
        cyc(op, 1'b0, w_ex,        1'b1, {tag, "_exec"});
    endtask

    task automatic instr_imm(input logic [5:0] op, input logic [16:0] w_ex, input string tag);
        cyc(op, 1'b1, W_FETCH_RDY, 1'b0, {tag, "_fetch"});
        cyc(op, 1'b0, W_DECODE,    1'b0, {tag, "_decode"});
        cyc(op, 1'b0, w_ex,        1'b0, {tag, "_exec"});
        cyc(op, 1'b0, W_IMM_WB,    1'b1, {tag, "_wb"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(OP_RTYPE, 1'b0, W_FETCH_WAIT, 1'b0, "reset");
        rst_n = 1'b1;

        // R-type; opcode changes after DECODE must not matter
        cyc(OP_RTYPE, 1'b1, W_FETCH_RDY, 1'b0, "rt_fetch");
        cyc(OP_RTYPE, 1'b0, W_DECODE,    1'b0, "rt_decode");
        cyc(OP_J,     1'b0, W_RTYPE_EX,  1'b0, "rt_ex");
        cyc(OP_J,     1'b0, W_RTYPE_WB,  1'b1, "rt_wb");

        // lw with three stalled MEM_RD cycles
        cyc(OP_LW, 1'b1, W_FETCH_RDY, 1'b0, "lw_fetch");
        cyc(OP_LW, 1'b0, W_DECODE,    1'b0, "lw_decode");
        cyc(OP_LW, 1'b0, W_MEM_ADR,   1'b0, "lw_adr");
        repeat (3) cyc(OP_LW, 1'b0, W_MEM_RD, 1'b0, "lw_rd_wait");
        cyc(OP_LW, 1'b1, W_MEM_RD,    1'b0, "lw_rd_ready");
        cyc(OP_LW, 1'b0, W_MEM_WB,    1'b1, "lw_wb");

        // sw; mem_ready in DECODE/MEM_ADR is ignored
        cyc(OP_SW, 1'b1, W_FETCH_RDY, 1'b0, "sw_fetch");
        cyc(OP_SW, 1'b1, W_DECODE,    1'b0, "sw_decode");
        cyc(OP_SW, 1'b1, W_MEM_ADR,   1'b0, "sw_adr");
        cyc(OP_SW, 1'b1, W_MEM_WR,    1'b1, "sw_wr");

        instr_short(OP_BEQ, W_BEQ,  "beq");
        instr_short(OP_BNE, W_BNE,  "bne");
        instr_short(OP_J,   W_JUMP, "j");
        instr_imm(OP_ADDI, W_ADDI_EX, "addi");
        instr_imm(OP_ANDI, W_ANDI_EX, "andi");

        // ready on the 16th waiting cycle is still a success
        repeat (15) cyc(OP_J, 1'b0, W_FETCH_WAIT, 1'b0, "fetch_wait15");
        cyc(OP_J, 1'b1, W_FETCH_RDY, 1'b0, "fetch_rdy16");
        cyc(OP_J, 1'b0, W_DECODE,    1'b0, "j16_decode");
        cyc(OP_J, 1'b0, W_JUMP,      1'b1, "j16_exec");

        // 16 not-ready cycles: timeout, FETCH again, count unchanged
        repeat (16) cyc(OP_J, 1'b0, W_FETCH_WAIT, 1'b0, "fetch_tmo");
        exp_tmo = 1'b1;
        instr_short(OP_BEQ, W_BEQ, "beq_after_tmo");

        // count is 10; six more retires wrap the 4-bit counter to 0
        repeat (6) instr_short(OP_J, W_JUMP, "j_wrap");
        chk("count_wrap", 32'(bus.instr_count), 32'd0);

`ifdef MCTRL_ILLEGAL_TRAP_EN
        cyc(6'h3F, 1'b1, W_FETCH_RDY, 1'b0, "ill_fetch");
        cyc(6'h3F, 1'b0, W_DECODE,    1'b0, "ill_decode");
        repeat (3) cyc(OP_RTYPE, 1'b1, W_TRAP, 1'b0, "trap_hold");
        chk("illegal_op_set", 32'(bus.illegal_op), 32'd1);
        rst_n   = 1'b0;
        exp_cnt = 4'd0;
        exp_tmo = 1'b0;
        cyc(OP_RTYPE, 1'b0, W_FETCH_WAIT, 1'b0, "trap_reset");
        rst_n = 1'b1;
        chk("illegal_op_clr", 32'(bus.illegal_op), 32'd0);
`else
        cyc(6'h3F, 1'b1, W_FETCH_RDY, 1'b0, "nop_fetch");
        cyc(6'h3F, 1'b0, W_DECODE,    1'b1, "nop_decode");
`endif

        // asynchronous reset in the middle of MEM_RD
        cyc(OP_LW, 1'b1, W_FETCH_RDY, 1'b0, "lwr_fetch");
        cyc(OP_LW, 1'b0, W_DECODE,    1'b0, "lwr_decode");
        cyc(OP_LW, 1'b0, W_MEM_ADR,   1'b0, "lwr_adr");
        cyc(OP_LW, 1'b0, W_MEM_RD,    1'b0, "lwr_rd_wait");
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_read", 32'(bus.mem_read),    32'd1);
        chk("rst_i_or_d",   32'(bus.i_or_d),      32'd0);
        chk("rst_count",    32'(bus.instr_count), 32'd0);
        chk("rst_timeout",  32'(bus.timeout_err), 32'd0);
        exp_cnt = 4'd0;
        exp_tmo = 1'b0;
        cyc(OP_LW, 1'b0, W_FETCH_WAIT, 1'b0, "rst_hold");
        rst_n = 1'b1;
        instr_short(OP_J, W_JUMP, "j_after_rst");
        chk("count_after_rst", 32'(bus.instr_count), 32'd1);

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore FSM sequencing each MIPS instruction over 3-5 states through a shared ALU and a single unified memory.
- Sits between the instruction register opcode field and the multicycle datapath.
- Adds a memory req/ready handshake with timeout, a retired-instruction counter, and bne/andi/j support.

Parameters:
ALUOP_W, 2, width of alu_op; values 00 add, 01 sub, 10 funct, 11 and; upper bits zero.
CNT_W, 32, width of instr_count.
TMO_CYCLES, 16, max cycles waiting for mem_ready before timeout; minimum 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the access in this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_write_cond_ne  out  1  PC load if ALU not zero (bne)
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
i_or_d  out  1  0 instruction address, 1 data address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch IR
mem_to_reg  out  1  writeback from MDR
reg_dst  out  1  1 rd, 0 rt
reg_write  out  1  register-file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 shifted imm
alu_op  out  ALUOP_W  ALU control class
instr_retired  out  1  one-cycle pulse on instruction completion
instr_count  out  CNT_W  retired-instruction count
timeout_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (async, rst_n=0): state FETCH, instr_count 0, timeout_err 0, wait counter 0. All control outputs are pure decode of state, so they take FETCH values during reset.
- States:
  - FETCH: mem_read, ir_write, alu_src_b=01, pc_write. Holds until mem_ready. ir_write and pc_write take effect only in the mem_ready cycle. Goes to DECODE.
  - DECODE: alu_src_b=11. Transitions by opcode:
    - 000000 -> RTYPE_EX
    - 100011/101011 -> MEM_ADR
    - 000100 -> BEQ
    - 000101 -> BNE
    - 001000 -> ADDI_EX
    - 001100 -> ANDI_EX
    - 000010 -> JUMP
    - other -> see Optional Feature
  - MEM_ADR: alu_src_a=1, alu_src_b=10. Goes to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_read, i_or_d. Holds until mem_ready, then MEM_WB.
  - MEM_WB: reg_write, mem_to_reg; retire.
  - MEM_WR: mem_write, i_or_d. Holds until mem_ready; retire.
  - RTYPE_EX: alu_src_a=1, alu_op=10. Goes to RTYPE_WB (reg_dst, reg_write; retire).
  - ADDI_EX/ANDI_EX: alu_src_a=1, alu_src_b=10, alu_op 00/11. Goes to IMM_WB (reg_write, reg_dst=0; retire).
  - BEQ/BNE: alu_src_a=1, alu_op=01, pc_src=01, pc_write_cond / pc_write_cond_ne; retire.
  - JUMP: pc_write, pc_src=10; retire.
- Retire:
  - Asserts instr_retired for exactly that cycle; next state is FETCH.
  - For MEM_WR, retire happens in its mem_ready cycle.
  - instr_count increments by 1 per retire and wraps from all-ones to 0.
- Memory wait:
  - A counter runs in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - On reaching TMO_CYCLES: set timeout_err (sticky until reset), abandon the access, go to FETCH, no retire, no pc_write/ir_write.
  - mem_ready in the same cycle the counter hits the limit means success (ready wins).
  - The counter clears on every state change.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- opcode is sampled only in DECODE and MEM_ADR; changes elsewhere have no effect.
- Reset asserted mid-instruction returns to FETCH immediately; no partial retire is counted.

Optional Feature:
- Macro MCTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE enters TRAP. TRAP holds all writes 0, stays until reset, and asserts extra output illegal_op=1 (port present only when defined).
- Undefined: an unknown opcode is treated as NOP, DECODE -> FETCH with instr_retired pulsed and counted.

Decomposition:
- Package mctrl_pkg holds:
  - state enum, 4-bit encoding, FETCH=0
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_J
  - ALUOP_ADD/SUB/FUNCT/AND
  - ALU source encodings
- One sub-module, mctrl_mem_timer: wait counter plus timeout compare, sized $clog2(TMO_CYCLES+1).
- Next-state logic and output decode stay in multicycle_control.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready=1 in FETCH -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB; reg_write=1 and reg_dst=1 in 4th cycle; instr_count=1.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read/i_or_d held 4 cycles, MEM_WB has mem_to_reg=1, total 8 cycles; sw with immediate ready -> retires in MEM_WR, 4 cycles.
- beq then bne -> pc_write_cond=1 only in BEQ, pc_write_cond_ne=1 only in BNE, alu_op=01, pc_src=01; j -> pc_write=1, pc_src=10; addi/andi -> alu_op 00/11.
- Hold mem_ready=0 in FETCH with TMO_CYCLES=16 -> timeout_err rises after 16 cycles, FETCH re-entered, instr_count unchanged; ready on 16th cycle -> no error.
- Force instr_count to all-ones (CNT_W=4 build, 15 retires) then one more retire -> count 0; rst_n low during MEM_RD -> FETCH asynchronously, count 0.
- Opcode 111111 -> with MCTRL_ILLEGAL_TRAP_EN: illegal_op=1, no writes, stuck until reset; without it: NOP, back to FETCH, count+1.
